// File: rtl/approx_mul_seq_pkg.sv
// Shared encodings and helpers for the sequential approximate multiplier.
package approx_mul_pkg;

    // Operation modes; encoding 3 is reserved and handled as exact.
    typedef enum logic [1:0] {
        MODE_EXACT      = 2'd0,
        MODE_TRUNC      = 2'd1,
        MODE_TRUNC_COMP = 2'd2,
        MODE_RESERVED   = 2'd3
    } mode_e;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Truncation point limited to the highest result column (2W-1).
    function automatic int unsigned clamp_k(input int unsigned k, input int unsigned w);
        int unsigned k_max;
        k_max = 2 * w - 1;
        return (k > k_max) ? k_max : k;
    endfunction

endpackage

// File: rtl/approx_mul_seq_if.sv
// Operand/result handshake bundle for approx_mul_seq.
interface approx_mul_seq_if #(
    parameter int W  = 8,
    parameter int KW = $clog2(2 * W)
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic [1:0]      in_mode;
    logic [KW-1:0]   in_k;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_p;

    modport master (
        output in_valid, in_a, in_b, in_mode, in_k, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, in_k, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/approx_mul_seq_pp_mask.sv
// Clears the k lowest columns of a 2W-bit partial product.
module approx_pp_mask #(
    parameter int W  = 8,
    parameter int KW = $clog2(2 * W)
) (
    input  logic [2*W-1:0] pp,
    input  logic [KW-1:0]  k,
    output logic [2*W-1:0] pp_masked
);

    // Keep a column only when it sits at or above the truncation point.
    always_comb begin
        pp_masked = '0;
        for (int i = 0; i < 2 * W; i++) begin
            pp_masked[i] = pp[i] & (i >= int'(k));
        end
    end

endmodule

// File: rtl/approx_mul_seq.sv
// Radix-2 shift-add approximate unsigned multiplier, one partial product
// per cycle, with per-operation column truncation and optional rounding
// compensation on the final accumulation.
module approx_mul_seq
    import approx_mul_pkg::*;
#(
    parameter int W  = 8,
    parameter int KW = $clog2(2 * W)
) (
    input  logic            clk,
    input  logic            rst_n,
    approx_mul_seq_if.slave bus
);

    localparam int PW = 2 * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_e          state;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [1:0]      mode_r;
    logic [KW-1:0]   k_r;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc;
    logic            out_valid_r;

    logic            accept;
    logic            last;
    logic            trunc_mode;
    logic [KW-1:0]   k_eff;
    logic [PW-1:0]   pp_raw;
    logic [PW-1:0]   pp_masked;
    logic [PW-1:0]   pp_add;
    logic [PW-1:0]   comp_term;
    logic [PW:0]     sum;

    assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
    assign bus.out_valid = out_valid_r;
    assign bus.out_p     = acc;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (cnt == CW'(W - 1));

    // Exact and reserved modes run with k forced to zero.
    assign trunc_mode = (bus.in_mode == MODE_TRUNC) || (bus.in_mode == MODE_TRUNC_COMP);
    assign k_eff      = trunc_mode ? KW'(clamp_k(int'(bus.in_k), W)) : '0;

    assign pp_raw = PW'(a_r) << cnt;

    approx_pp_mask #(.W(W), .KW(KW)) u_mask (
        .pp        (pp_raw),
        .k         (k_r),
        .pp_masked (pp_masked)
    );

    // Partial product selection and half-LSB rounding term on the last step.
    always_comb begin
        pp_add    = b_r[cnt] ? pp_masked : '0;
        comp_term = '0;
        if (last && mode_r == MODE_TRUNC_COMP && k_r != '0) begin
            comp_term = PW'(1) << (k_r - 1'b1);
        end
        sum = {1'b0, acc} + {1'b0, pp_add} + {1'b0, comp_term};
    end

    // Controller, operand latches, counter and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            mode_r      <= '0;
            k_r         <= '0;
            cnt         <= '0;
            acc         <= '0;
            out_valid_r <= 1'b0;
        end else if (accept) begin
            state       <= BUSY;
            a_r         <= bus.in_a;
            b_r         <= bus.in_b;
            mode_r      <= bus.in_mode;
            k_r         <= k_eff;
            cnt         <= '0;
            acc         <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    acc <= sum[PW-1:0];
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The masked sum plus compensation always fits in 2W bits.
    assert property (@(posedge clk) disable iff (!rst_n) (state == BUSY) |-> !sum[PW]);

endmodule

// File: tb/tb_approx_mul_seq.sv
// Directed bench for approx_mul_seq: vector table plus handshake and
// reset sequences on a default instance and a wide-k instance.
module tb_approx_mul_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    approx_mul_seq_if #(.W(8))          bus0 ();
    approx_mul_seq_if #(.W(8), .KW(6))  bus1 ();

    approx_mul_seq #(.W(8)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    approx_mul_seq #(.W(8), .KW(6)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    typedef struct {
        bit          sel;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  mode;
        logic [5:0]  k;
        logic [15:0] exp_p;
    } vec_t;

    vec_t vecs[14];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic ov(input bit sel);
        return sel ? bus1.out_valid : bus0.out_valid;
    endfunction

    // Waits up to 20 cycles for out_valid; lat is 0 on timeout.
    task automatic wait_valid(input bit sel, output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (ov(sel)) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic pulse_ready(input bit sel);
        if (sel) bus1.out_ready = 1'b1; else bus0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b0;
        bus1.out_ready = 1'b0;
    endtask

    task automatic do_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] m, input logic [5:0] k,
                         output logic [15:0] p, output int lat);
        @(negedge clk);
        if (sel) begin
            bus1.in_a = a; bus1.in_b = b; bus1.in_mode = m; bus1.in_k = k;
            bus1.in_valid = 1'b1;
        end else begin
            bus0.in_a = a; bus0.in_b = b; bus0.in_mode = m; bus0.in_k = k[3:0];
            bus0.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        wait_valid(sel, lat);
        p = sel ? bus1.out_p : bus0.out_p;
        pulse_ready(sel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] p;
        int          lat;
        bit          seen;

        vecs[0]  = '{0, 8'd200, 8'd100, 2'd0, 6'd0,  16'd20000};
        vecs[1]  = '{0, 8'd255, 8'd255, 2'd1, 6'd8,  16'd63232};
        vecs[2]  = '{0, 8'd255, 8'd255, 2'd0, 6'd8,  16'd65025};
        vecs[3]  = '{0, 8'd255, 8'd255, 2'd2, 6'd8,  16'd63360};
        vecs[4]  = '{0, 8'd255, 8'd255, 2'd2, 6'd14, 16'd24576};
        vecs[5]  = '{0, 8'd3,   8'd5,   2'd3, 6'd4,  16'd15};
        vecs[6]  = '{0, 8'd255, 8'd255, 2'd1, 6'd0,  16'd65025};
        vecs[7]  = '{0, 8'd255, 8'd255, 2'd2, 6'd15, 16'd16384};
        vecs[8]  = '{1, 8'd255, 8'd255, 2'd2, 6'd15, 16'd16384};
        vecs[9]  = '{1, 8'd255, 8'd255, 2'd2, 6'd31, 16'd16384};
        vecs[10] = '{1, 8'd255, 8'd255, 2'd2, 6'd40, 16'd16384};
        vecs[11] = '{0, 8'd0,   8'd0,   2'd2, 6'd1,  16'd1};
        vecs[12] = '{0, 8'd13,  8'd11,  2'd1, 6'd3,  16'd136};
        vecs[13] = '{0, 8'd13,  8'd11,  2'd2, 6'd3,  16'd140};

        rst_n = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_mode = '0;
        bus0.in_k = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_mode = '0;
        bus1.in_k = '0; bus1.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus0.in_ready), 32'd1);
        check("reset out_valid", 32'(bus0.out_valid), 32'd0);
        check("reset out_p", 32'(bus0.out_p), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].k, p, lat);
            check($sformatf("vec%0d out_p", i), 32'(p), 32'(vecs[i].exp_p));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d drained", i), 32'(ov(vecs[i].sel)), 32'd0);
        end

        // Stall with out_ready low, then back-to-back accept on release.
        @(negedge clk);
        bus0.in_a = 8'd10; bus0.in_b = 8'd10; bus0.in_mode = 2'd0; bus0.in_k = '0;
        bus0.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        bus0.in_a = 8'd99; bus0.in_mode = 2'd1; bus0.in_k = 4'd5;
        wait_valid(1'b0, lat);
        check("stall latency", 32'(lat), 32'd8);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d out_p", c), 32'(bus0.out_p), 32'd100);
            check($sformatf("stall%0d in_ready", c), 32'(bus0.in_ready), 32'd0);
            check($sformatf("stall%0d out_valid", c), 32'(bus0.out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        bus0.in_a = 8'd7; bus0.in_b = 8'd6; bus0.in_mode = 2'd0; bus0.in_k = '0;
        bus0.in_valid = 1'b1;
        bus0.out_ready = 1'b1;
        #1;
        check("b2b in_ready", 32'(bus0.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b0;
        check("b2b out_valid low", 32'(bus0.out_valid), 32'd0);
        wait_valid(1'b0, lat);
        check("b2b latency", 32'(lat), 32'd8);
        check("b2b out_p", 32'(bus0.out_p), 32'd42);
        pulse_ready(1'b0);

        // Reset asserted on the third busy cycle.
        @(negedge clk);
        bus0.in_a = 8'd255; bus0.in_b = 8'd255; bus0.in_mode = 2'd0; bus0.in_k = '0;
        bus0.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(bus0.out_valid), 32'd0);
        check("abort out_p", 32'(bus0.out_p), 32'd0);
        check("abort in_ready", 32'(bus0.in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus0.out_valid) seen = 1'b1;
        end
        check("abort no stale result", 32'(seen), 32'd0);
        do_op(1'b0, 8'd7, 8'd9, 2'd0, 6'd0, p, lat);
        check("post-reset out_p", 32'(p), 32'd63);
        check("post-reset latency", 32'(lat), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
